// File: rtl/core_pkg.sv
// Shared types for the multicycle RV32I-subset control path.
// Holds the ALU operation encodings, opcode constants, datapath select
// enums, the opcode classifier and the main control FSM state type.
package core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_NOR = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'd0,
    SRCA_OLDPC = 2'd1,
    SRCA_RS1   = 2'd2
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_FOUR = 2'd2
  } alu_src_b_e;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2,
    IMM_J = 2'd3
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALUOUT  = 2'd0,
    RES_MEMDATA = 2'd1,
    RES_ALU     = 2'd2
  } result_src_e;

  typedef enum logic [2:0] {
    OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_ILLEGAL
  } opc_class_e;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
    S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JAL, S_TRAP
  } state_e;

  // Map a raw opcode onto the instruction class the control path handles.
  function automatic opc_class_e opc_classify(input logic [6:0] opcode);
    case (opcode)
      OP_R:      return OPC_R;
      OP_I:      return OPC_I;
      OP_LOAD:   return OPC_LOAD;
      OP_STORE:  return OPC_STORE;
      OP_BRANCH: return OPC_BRANCH;
      OP_JAL:    return OPC_JAL;
      default:   return OPC_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the main controller and the datapath.
// master: controller side (drives selects, strobes, memory request, trap).
// slave : datapath/memory side (drives IR contents, ALU flags, mem_ready).
interface multicycle_ctrl_if;
  import core_pkg::*;

  logic [XLEN-1:0] instr;
  logic            alu_zero;
  logic            alu_ovf;
  logic            mem_ready;
  logic            mem_req;
  logic            mem_we;
  logic            adr_src;
  logic            ir_we;
  logic            pc_we;
  logic            reg_we;
  alu_src_a_e      alu_src_a;
  alu_src_b_e      alu_src_b;
  imm_src_e        imm_src;
  result_src_e     result_src;
  alu_op_e         alu_ctrl;
  logic            trap;

  modport master (
    input  instr, alu_zero, alu_ovf, mem_ready,
    output mem_req, mem_we, adr_src, ir_we, pc_we, reg_we,
           alu_src_a, alu_src_b, imm_src, result_src, alu_ctrl, trap
  );

  modport slave (
    output instr, alu_zero, alu_ovf, mem_ready,
    input  mem_req, mem_we, adr_src, ir_we, pc_we, reg_we,
           alu_src_a, alu_src_b, imm_src, result_src, alu_ctrl, trap
  );
endinterface

// File: rtl/alu_decoder.sv
// ALU operation decoder: (opcode class, funct3, funct7[5]) -> alu_ctrl.
// Ports: opc_class, funct3, funct7_5 in; alu_ctrl, illegal out.
// illegal flags encodings outside the supported subset.
module alu_decoder
  import core_pkg::*;
(
  input  opc_class_e  opc_class,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  output alu_op_e     alu_ctrl,
  output logic        illegal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (opc_class)
      OPC_R, OPC_I: begin
        case (funct3)
          3'b000:  alu_ctrl = (opc_class == OPC_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_ctrl = ALU_AND;
          3'b110:  alu_ctrl = ALU_OR;
          3'b010:  alu_ctrl = ALU_SLT;
          default: illegal  = 1'b1;
        endcase
        // Only sub uses the alternate funct7 in the R-type subset.
        if (opc_class == OPC_R && funct7_5 && funct3 != 3'b000) illegal = 1'b1;
      end
      OPC_LOAD, OPC_STORE: illegal = (funct3 != 3'b010);
      OPC_BRANCH: begin
        alu_ctrl = ALU_SUB;
        illegal  = !(funct3 == 3'b000 || funct3 == 3'b001);
      end
      OPC_JAL: alu_ctrl = ALU_ADD;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle main control FSM for the RV32I-subset core.
// Ports: clk, rst_n (synchronous, active-low), bus (multicycle_ctrl_if.master).
// Outputs are Moore decodes of state and instr; FETCH/MEM_* strobes are
// qualified by mem_ready and BRANCH pc_we by alu_zero. All outputs are
// forced to 0 while rst_n is low (trap too, unless RESET_TRAP_CLR=0).
// Build option: define ALU_OVF_TRAP_EN to trap on signed overflow of
// ADD/SUB in EXEC_R/EXEC_I instead of writing back.
module multicycle_ctrl
  import core_pkg::*;
#(
  parameter bit RESET_TRAP_CLR = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  state_e     state_q, state_d;
  logic       trap_q, trap_d;
  opc_class_e opc_class;
  alu_op_e    dec_alu_ctrl;
  logic       dec_illegal;
  logic       ovf_trap;
  logic       unused_instr;

  assign opc_class    = opc_classify(bus.instr[6:0]);
  assign unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  alu_decoder u_alu_decoder (
    .opc_class (opc_class),
    .funct3    (bus.instr[14:12]),
    .funct7_5  (bus.instr[30]),
    .alu_ctrl  (dec_alu_ctrl),
    .illegal   (dec_illegal)
  );

`ifdef ALU_OVF_TRAP_EN
  assign ovf_trap = bus.alu_ovf && (dec_alu_ctrl == ALU_ADD || dec_alu_ctrl == ALU_SUB);
`else
  logic unused_ovf;
  assign unused_ovf = bus.alu_ovf;
  assign ovf_trap   = 1'b0;
`endif

  // State and sticky trap registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      if (RESET_TRAP_CLR) trap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
    end
  end

  assign trap_d   = trap_q | (state_d == S_TRAP);
  assign bus.trap = trap_q & (rst_n | ~RESET_TRAP_CLR);

  // Next-state and output decode.
  always_comb begin
    state_d        = state_q;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.adr_src    = 1'b0;
    bus.ir_we      = 1'b0;
    bus.pc_we      = 1'b0;
    bus.reg_we     = 1'b0;
    bus.alu_src_a  = SRCA_PC;
    bus.alu_src_b  = SRCB_RS2;
    bus.imm_src    = IMM_I;
    bus.result_src = RES_ALUOUT;
    bus.alu_ctrl   = ALU_AND;

    case (state_q)
      S_FETCH: begin
        bus.mem_req    = 1'b1;
        bus.alu_src_a  = SRCA_PC;
        bus.alu_src_b  = SRCB_FOUR;
        bus.alu_ctrl   = ALU_ADD;
        bus.result_src = RES_ALU;
        if (bus.mem_ready) begin
          bus.ir_we = 1'b1;
          bus.pc_we = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        // Latch the branch/jump target into ALUOut.
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_ctrl  = ALU_ADD;
        if (opc_class == OPC_BRANCH) bus.imm_src = IMM_B;
        else if (opc_class == OPC_JAL) bus.imm_src = IMM_J;
        if (dec_illegal) state_d = S_TRAP;
        else begin
          case (opc_class)
            OPC_R:               state_d = S_EXEC_R;
            OPC_I:               state_d = S_EXEC_I;
            OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
            OPC_BRANCH:          state_d = S_BRANCH;
            OPC_JAL:             state_d = S_JAL;
            default:             state_d = S_TRAP;
          endcase
        end
      end
      S_EXEC_R, S_EXEC_I: begin
        bus.alu_src_a = SRCA_RS1;
        bus.alu_src_b = (state_q == S_EXEC_I) ? SRCB_IMM : SRCB_RS2;
        bus.alu_ctrl  = dec_alu_ctrl;
        state_d       = ovf_trap ? S_TRAP : S_ALU_WB;
      end
      S_ALU_WB: begin
        bus.reg_we     = 1'b1;
        bus.result_src = RES_ALUOUT;
        state_d        = S_FETCH;
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = SRCA_RS1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_ctrl  = ALU_ADD;
        bus.imm_src   = (opc_class == OPC_STORE) ? IMM_S : IMM_I;
        state_d       = (opc_class == OPC_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        bus.reg_we     = 1'b1;
        bus.result_src = RES_MEMDATA;
        state_d        = S_FETCH;
      end
      S_MEM_WRITE: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.adr_src = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a  = SRCA_RS1;
        bus.alu_src_b  = SRCB_RS2;
        bus.alu_ctrl   = ALU_SUB;
        bus.result_src = RES_ALUOUT;
        state_d        = S_FETCH;
        case (bus.instr[14:12])
          3'b000:  bus.pc_we = bus.alu_zero;
          3'b001:  bus.pc_we = ~bus.alu_zero;
          default: state_d   = S_TRAP;
        endcase
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4.
        bus.pc_we      = 1'b1;
        bus.result_src = RES_ALUOUT;
        bus.alu_src_a  = SRCA_OLDPC;
        bus.alu_src_b  = SRCB_FOUR;
        bus.alu_ctrl   = ALU_ADD;
        state_d        = S_ALU_WB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // Reset aborts any transaction in flight and silences every strobe.
    if (!rst_n) begin
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.adr_src    = 1'b0;
      bus.ir_we      = 1'b0;
      bus.pc_we      = 1'b0;
      bus.reg_we     = 1'b0;
      bus.alu_src_a  = SRCA_PC;
      bus.alu_src_b  = SRCB_RS2;
      bus.imm_src    = IMM_I;
      bus.result_src = RES_ALUOUT;
      bus.alu_ctrl   = ALU_AND;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each cycle pushes the expected output
// vector to a scoreboard, then pops and compares it at the falling edge.
// Vector layout: {mem_req, mem_we, adr_src, ir_we, pc_we, reg_we,
//                 alu_src_a[1:0], alu_src_b[1:0], imm_src[1:0],
//                 result_src[1:0], alu_ctrl[3:0], trap}
module tb_multicycle_ctrl;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.RESET_TRAP_CLR(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [18:0] val;
  } sb_t;

  sb_t sb_q[$];

  function automatic logic [18:0] ov(
    input logic req, input logic we, input logic adr, input logic irw,
    input logic pcw, input logic rgw, input logic [1:0] a, input logic [1:0] b,
    input logic [1:0] imm, input logic [1:0] res, input logic [3:0] alu,
    input logic trp);
    return {req, we, adr, irw, pcw, rgw, a, b, imm, res, alu, trp};
  endfunction

  function automatic logic [18:0] observed();
    return {bus.mem_req, bus.mem_we, bus.adr_src, bus.ir_we, bus.pc_we,
            bus.reg_we, bus.alu_src_a, bus.alu_src_b, bus.imm_src,
            bus.result_src, bus.alu_ctrl, bus.trap};
  endfunction

  // One clock: drive inputs, queue the expectation, compare at negedge.
  task automatic cyc(input string tag, input logic rdy, input logic zro,
                     input logic ovf, input logic [18:0] exp_v);
    sb_t e;
    logic [18:0] obs;
    bus.mem_ready = rdy;
    bus.alu_zero  = zro;
    bus.alu_ovf   = ovf;
    sb_q.push_back('{tag, exp_v});
    @(negedge clk);
    e   = sb_q.pop_front();
    obs = observed();
    checks++;
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
    @(posedge clk);
    #1;
  endtask

  logic [18:0] V_ZERO, V_F0, V_F1, V_DEC_I, V_DEC_B, V_DEC_J, V_WB, V_TRAP;
  logic [18:0] V_MRD, V_MWB, V_MWR;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    V_ZERO  = '0;
    V_F0    = ov(1,0,0,0,0,0, 2'd0,2'd2,2'd0,2'd2,4'd2,0);
    V_F1    = ov(1,0,0,1,1,0, 2'd0,2'd2,2'd0,2'd2,4'd2,0);
    V_DEC_I = ov(0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0,4'd2,0);
    V_DEC_B = ov(0,0,0,0,0,0, 2'd1,2'd1,2'd2,2'd0,4'd2,0);
    V_DEC_J = ov(0,0,0,0,0,0, 2'd1,2'd1,2'd3,2'd0,4'd2,0);
    V_WB    = ov(0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0,4'd0,0);
    V_TRAP  = ov(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,4'd0,1);
    V_MRD   = ov(1,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0,4'd0,0);
    V_MWB   = ov(0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd1,4'd0,0);
    V_MWR   = ov(1,1,1,0,0,0, 2'd0,2'd0,2'd0,2'd0,4'd0,0);

    rst_n         = 1'b0;
    bus.instr     = '0;
    bus.mem_ready = 1'b0;
    bus.alu_zero  = 1'b0;
    bus.alu_ovf   = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset_low", 0,0,0, V_ZERO);
    rst_n = 1'b1;
    cyc("fetch_hold", 0,0,0, V_F0);

    // add x3,x1,x2
    bus.instr = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    cyc("add_fetch",  1,0,0, V_F1);
    cyc("add_decode", 0,0,0, V_DEC_I);
    cyc("add_exec",   0,0,0, ov(0,0,0,0,0,0, 2'd2,2'd0,2'd0,2'd0,4'd2,0));
    cyc("add_wb",     0,0,0, V_WB);

    // sub x3,x1,x2 with signed overflow
    bus.instr = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    cyc("sub_fetch",  1,0,1, V_F1);
    cyc("sub_decode", 0,0,1, V_DEC_I);
    cyc("sub_exec",   0,0,1, ov(0,0,0,0,0,0, 2'd2,2'd0,2'd0,2'd0,4'd6,0));
`ifdef ALU_OVF_TRAP_EN
    cyc("sub_ovf_trap", 0,0,1, V_TRAP);
    rst_n = 1'b0;
    cyc("sub_ovf_rst",  0,0,0, V_ZERO);
    rst_n = 1'b1;
`else
    cyc("sub_ovf_wb",   0,0,1, V_WB);
`endif

    // addi with instr[30] set must still add
    bus.instr = {12'h400, 5'd1, 3'b000, 5'd4, 7'b0010011};
    cyc("addi_fetch",  1,0,0, V_F1);
    cyc("addi_decode", 0,0,0, V_DEC_I);
    cyc("addi_exec",   0,0,0, ov(0,0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0,4'd2,0));
    cyc("addi_wb",     0,0,0, V_WB);

    // ori
    bus.instr = {12'h0F0, 5'd1, 3'b110, 5'd4, 7'b0010011};
    cyc("ori_fetch",  1,0,0, V_F1);
    cyc("ori_decode", 0,0,0, V_DEC_I);
    cyc("ori_exec",   0,0,0, ov(0,0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0,4'd1,0));
    cyc("ori_wb",     0,0,0, V_WB);

    // lw x5,8(x1) with three memory wait cycles
    bus.instr = {12'd8, 5'd1, 3'b010, 5'd5, 7'b0000011};
    cyc("lw_fetch",  1,0,0, V_F1);
    cyc("lw_decode", 0,0,0, V_DEC_I);
    cyc("lw_addr",   0,0,0, ov(0,0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0,4'd2,0));
    for (int i = 0; i < 3; i++) cyc("lw_read_wait", 0,0,0, V_MRD);
    cyc("lw_read_done", 1,0,0, V_MRD);
    cyc("lw_wb",        0,0,0, V_MWB);

    // sw x2,12(x1) with one wait cycle, completes
    bus.instr = {7'd0, 5'd2, 5'd1, 3'b010, 5'b01100, 7'b0100011};
    cyc("sw_fetch",  1,0,0, V_F1);
    cyc("sw_decode", 0,0,0, V_DEC_I);
    cyc("sw_addr",   0,0,0, ov(0,0,0,0,0,0, 2'd2,2'd1,2'd1,2'd0,4'd2,0));
    cyc("sw_wait",   0,0,0, V_MWR);
    cyc("sw_done",   1,0,0, V_MWR);

    // sw aborted by reset while mem_ready is low
    cyc("swa_fetch",  1,0,0, V_F1);
    cyc("swa_decode", 0,0,0, V_DEC_I);
    cyc("swa_addr",   0,0,0, ov(0,0,0,0,0,0, 2'd2,2'd1,2'd1,2'd0,4'd2,0));
    cyc("swa_wait",   0,0,0, V_MWR);
    rst_n = 1'b0;
    cyc("swa_rst",    0,0,0, V_ZERO);
    rst_n = 1'b1;
    cyc("swa_refetch", 0,0,0, V_F0);

    // beq taken
    bus.instr = {7'd0, 5'd2, 5'd1, 3'b000, 5'd8, 7'b1100011};
    cyc("beq_fetch",  1,0,0, V_F1);
    cyc("beq_decode", 0,1,0, V_DEC_B);
    cyc("beq_branch", 0,1,0, ov(0,0,0,0,1,0, 2'd2,2'd0,2'd0,2'd0,4'd6,0));

    // bne with zero set: not taken, then zero clear: taken
    bus.instr = {7'd0, 5'd2, 5'd1, 3'b001, 5'd8, 7'b1100011};
    cyc("bne_fetch",  1,0,0, V_F1);
    cyc("bne_decode", 0,1,0, V_DEC_B);
    cyc("bne_nt",     0,1,0, ov(0,0,0,0,0,0, 2'd2,2'd0,2'd0,2'd0,4'd6,0));
    cyc("bne2_fetch", 1,0,0, V_F1);
    cyc("bne2_decode",0,0,0, V_DEC_B);
    cyc("bne_t",      0,0,0, ov(0,0,0,0,1,0, 2'd2,2'd0,2'd0,2'd0,4'd6,0));

    // jal x1
    bus.instr = {20'h00100, 5'd1, 7'b1101111};
    cyc("jal_fetch",  1,0,0, V_F1);
    cyc("jal_decode", 0,0,0, V_DEC_J);
    cyc("jal_exec",   0,0,0, ov(0,0,0,0,1,0, 2'd1,2'd2,2'd0,2'd0,4'd2,0));
    cyc("jal_wb",     0,0,0, V_WB);

    // branch with unsupported funct3
    bus.instr = {7'd0, 5'd2, 5'd1, 3'b100, 5'd8, 7'b1100011};
    cyc("badbr_fetch",  1,0,0, V_F1);
    cyc("badbr_decode", 0,0,0, V_DEC_B);
    cyc("badbr_trap",   0,0,0, V_TRAP);
    rst_n = 1'b0;
    cyc("badbr_rst",    0,0,0, V_ZERO);
    rst_n = 1'b1;

    // illegal opcode 0x7F: absorbing trap, then reset recovers
    bus.instr = 32'h0000007F;
    cyc("ill_fetch",  1,0,0, V_F1);
    cyc("ill_decode", 0,0,0, V_DEC_I);
    for (int i = 0; i < 10; i++) cyc("ill_trap_hold", i[0],i[1],0, V_TRAP);
    rst_n = 1'b0;
    cyc("ill_rst",    1,0,0, V_ZERO);
    rst_n = 1'b1;
    cyc("ill_refetch", 0,0,0, V_F0);

    checks++;
    assert (sb_q.size() === 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
